// File: rtl/tx_feeder.sv
// -----------------------------------------------------------------------------
// tx_feeder
//
// Upstream byte source for the transmission controller. Bytes from a local
// producer are buffered in a small FIFO and offered to the controller in
// bursts of at most BURST_MAX bytes. After each burst, REQ is held low for at
// least one cycle. The feeder backs off while the controller raises an
// exception or is not idle.
//
// Optional feature, selected by the macro TX_FEEDER_TIMEOUT_EN:
//   A burst is aborted if no ACK arrives within TIMEOUT XFER cycles.
//   This abort sets ERR and TMO. Without the macro, TMO is tied low and XFER
//   waits for ACK indefinitely.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous reset, active-low
//   en         feeder enable; only gates the start of new bursts
//   wr_en      producer write strobe
//   wr_data    producer byte
//   full       FIFO full (combinational from level)
//   empty      FIFO empty (combinational from level)
//   level      bytes stored (registered)
//   req        transfer request to the controller (registered)
//   data       FIFO head while drdy=1, 8'h00 otherwise
//   drdy       data valid (registered)
//   ack        controller accepted data this cycle
//   exc        controller exception
//   idl        controller idle
//   err        sticky: burst aborted by exc or timeout
//   ovf        sticky: write dropped while full
//   tmo        sticky: timeout abort
//   dbg_state  current FSM state (0 IDLE, 1 XFER, 2 GAP, 3 ABORT)
//
// Handshake: a byte moves to the controller exactly in a cycle where the FSM
// is in XFER, drdy=1, ack=1 and exc=0. That cycle pops the FIFO head.
// If exc and ack are both high, exc wins and the byte stays at the head.
// -----------------------------------------------------------------------------
module tx_feeder #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          req,
    output logic [7:0]    data,
    output logic          drdy,
    input  logic          ack,
    input  logic          exc,
    input  logic          idl,
    output logic          err,
    output logic          ovf,
    output logic          tmo,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_GAP   = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] BURST_L = (AW+1)'(BURST_MAX);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   burst_cnt;
    logic          pop;
    logic          wr_accept;
    logic          last_pop;
    logic          tmo_hit;

    assign full      = (level == DEPTH_L);
    assign empty     = (level == '0);
    assign dbg_state = state;

    assign pop       = (state == ST_XFER) && drdy && ack && !exc;
    // A pop frees a slot in the same cycle, so a full FIFO still takes a write.
    assign wr_accept = wr_en && (!full || pop);
    // The burst ends on the pop that reaches BURST_MAX or drains the FIFO.
    assign last_pop  = pop && (((burst_cnt + 1'b1) == BURST_L) ||
                               ((level == ONE_L) && !wr_accept));

    assign data = drdy ? mem[rd_ptr] : 8'h00;

    // Storage array: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (reset_n && wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH == 2**AW.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_accept && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !wr_accept) begin
                level <= level - 1'b1;
            end
            if (wr_en && !wr_accept) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef TX_FEEDER_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;

    // Count XFER cycles since entry or since the last pop.
    // The counter is held at zero outside XFER, so every entry starts from 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if ((state != ST_XFER) || pop) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // The TIMEOUT-th cycle without a pop aborts. If exc is high in that cycle,
    // the exception handles the abort instead.
    assign tmo_hit = (state == ST_XFER) && !exc && !pop && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo <= 1'b0;
        end else if (tmo_hit) begin
            tmo <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    // TIMEOUT has no effect in this build; tmo is held low.
    assign tmo     = 1'b0 && (TIMEOUT > 0);
`endif

    // Burst controller. req/drdy are registered and change together with
    // the state, so they are high in every cycle spent in XFER.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            req       <= 1'b0;
            drdy      <= 1'b0;
            err       <= 1'b0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en && idl && (level != '0)) begin
                        state     <= ST_XFER;
                        req       <= 1'b1;
                        drdy      <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                ST_XFER: begin
                    if (exc) begin
                        state <= ST_ABORT;
                        req   <= 1'b0;
                        drdy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (pop) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (last_pop) begin
                            state <= ST_GAP;
                            req   <= 1'b0;
                            drdy  <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        state <= ST_ABORT;
                        req   <= 1'b0;
                        drdy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                ST_ABORT: begin
                    if (idl && !exc) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                    drdy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tx_feeder.md
Name: tx_feeder

Overview:
Upstream byte source for the transmission controller. It buffers bytes from a local producer in a small FIFO and presents them to the controller as bursts on DATA/DRDY under REQ. It pops one byte per ACK, and it backs off on EXC or while the controller is not idle.

Parameters:
DEPTH, 8, FIFO depth in bytes (power of two, at least 2)
AW, 3, address width; log2(DEPTH)
BURST_MAX, 4, maximum bytes per REQ burst (1..DEPTH)
TIMEOUT, 16, cycles allowed between ACKs in a burst (used only with the optional feature)

Ports:
CLK  in  1  rising-edge clock
RESET_N  in  1  synchronous reset, active-low
EN  in  1  feeder enable; gates the start of new bursts only
WR_EN  in  1  producer write strobe
WR_DATA  in  8  producer byte
FULL  out  1  FIFO full (combinational from count)
EMPTY  out  1  FIFO empty (combinational from count)
LEVEL  out  AW+1  bytes stored
REQ  out  1  transfer request to controller
DATA  out  8  head byte to controller
DRDY  out  1  DATA valid
ACK  in  1  controller accepted DATA this cycle
EXC  in  1  controller exception
IDL  in  1  controller idle
ERR  out  1  sticky: burst aborted by EXC or timeout
OVF  out  1  sticky: write dropped while full
TMO  out  1  sticky: timeout abort (tied 0 without the feature)

Behaviour:
- Reset (RESET_N low at a CLK edge):
  - FIFO is emptied; LEVEL=0; EMPTY=1; FULL=0.
  - REQ=0, DRDY=0, DATA=8'h00, ERR=0, OVF=0, TMO=0.
  - State goes to IDLE. Reset overrides all other activity in that cycle, including an in-flight burst; no pop happens.
- FIFO write:
  - Accepted when WR_EN=1 and (not FULL, or a pop occurs in the same cycle).
  - Otherwise the byte is dropped and OVF is set.
  - Write and pop in the same cycle leaves LEVEL unchanged.
  - Pointers wrap modulo DEPTH.
- Pop: occurs when state is XFER, DRDY=1, ACK=1 and EXC=0.
- DATA equals the FIFO head while DRDY=1, and 8'h00 otherwise.
- All outputs except FULL, EMPTY and DATA are registered.
- States (REQ and DRDY are registered, asserted from the cycle after entering XFER):
  - IDLE: REQ=0, DRDY=0.
    - Go to XFER when EN=1, IDL=1 and LEVEL!=0.
    - The burst counter clears on entry to XFER.
  - XFER: REQ=1, DRDY=1.
    - Each pop increments the burst counter.
    - After a pop that makes the counter equal BURST_MAX, or that empties the FIFO (LEVEL 1 with no simultaneous write), go to GAP.
    - EXC=1 goes to ABORT; EXC takes priority over ACK in the same cycle, so there is no pop and the byte is retried in a later burst.
    - EN falling mid-burst does not end the burst.
  - GAP: REQ=0, DRDY=0 for exactly one cycle, then IDLE. This guarantees at least one REQ-low cycle between bursts.
  - ABORT: REQ=0, DRDY=0; ERR set.
    - Stay in ABORT until IDL=1 and EXC=0, then go to IDLE.
- Latency:
  - Byte written to an empty FIFO in cycle n: REQ and DRDY high at edge n+2, given EN=1 and IDL=1.
  - One byte per cycle is transferred when ACK is held high.
- ACK outside XFER is ignored. EXC outside XFER and ABORT is ignored.
- ERR, OVF and TMO clear only on reset.

Optional Feature:
- Macro: TX_FEEDER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in XFER. It resets on entry to XFER and on every pop.
  - When it reaches TIMEOUT without an ACK, the FSM goes to ABORT, setting ERR and TMO; no pop occurs.
- Undefined:
  - The counter logic is absent and TMO is tied to 0.
  - XFER waits for ACK indefinitely.

Test Plan:
- Reset and basic burst:
  - Stimulus: RESET_N=0 for 2 cycles, then EN=1, IDL=1; write 8'hAA, 8'h55; ACK held 1.
  - Required: DATA shows AA then 55 on consecutive cycles with REQ=1; then REQ=0 for one cycle; LEVEL returns to 0; ERR=0.
- Burst limit:
  - Stimulus: write 8'h01..8'h06 with BURST_MAX=4; ACK held 1.
  - Required: burst 1 transfers 01..04; REQ low exactly one cycle; burst 2 transfers 05,06.
- Exception retry:
  - Stimulus: write 8'h10, 8'h20; assert ACK and EXC together on the first DRDY cycle; raise IDL 3 cycles later.
  - Required: no pop; ERR=1; REQ=0 until IDL; next burst starts with 8'h10.
- Overflow and wrap:
  - Stimulus: write 9 bytes 8'hC0..8'hC8 with EN=0 and DEPTH=8.
  - Required: FULL=1, OVF=1, LEVEL=8; after EN=1 the outputs are C0..C7, showing pointer wrap; C8 is lost.
- Simultaneous write/pop at full:
  - Stimulus: FIFO full, XFER active, WR_EN=1 and ACK=1 in the same cycle.
  - Required: LEVEL stays 8; OVF unchanged; the new byte appears last.
- Timeout (TX_FEEDER_TIMEOUT_EN defined, TIMEOUT=16):
  - Stimulus: one byte, ACK held 0.
  - Required: after 16 XFER cycles, REQ=0, TMO=1, ERR=1, LEVEL=1.
  - Without the macro: REQ stays 1 and TMO=0.
